// File: rtl/operand_loader_if.sv
// Operand stream in, parallel A-D frame out.
// slave is the loader's view; master is the environment's view.
interface operand_loader_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       load_idx;
    logic [CNT_W-1:0] frame_cnt;

    modport slave (
        input  in_data, in_valid, abort, out_ready,
        output in_ready, A, B, C, D, out_valid, load_idx, frame_cnt
    );

    modport master (
        output in_data, in_valid, abort, out_ready,
        input  in_ready, A, B, C, D, out_valid, load_idx, frame_cnt
    );
endinterface

// File: rtl/operand_loader.sv
// Collects four nibbles A,B,C,D serially and holds them as one
// parallel frame until the downstream operator stage accepts it.
module operand_loader #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    operand_loader_if.slave    bus
);
    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_ops [4];
    logic [CNT_W-1:0] r_cnt;
    logic             w_take;
    logic             w_accept;

    // abort outranks both handshakes in either state
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            LOAD: begin
                w_take = bus.in_valid && !bus.abort;
                if (w_take && r_idx == 2'd3)
                    w_state_nxt = HOLD;
            end
            HOLD: begin
                w_accept = bus.out_ready && !bus.abort;
                if (bus.abort || bus.out_ready)
                    w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_cnt <= '0;
            for (int i = 0; i < 4; i++)
                r_ops[i] <= '0;
        end else begin
            if (bus.abort && r_state == LOAD) begin
                r_idx <= 2'd0;
            end else if (w_take) begin
                r_ops[r_idx] <= bus.in_data;
                r_idx        <= r_idx + 2'd1;
            end
            if (w_accept)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.load_idx  = r_idx;
    assign bus.frame_cnt = r_cnt;
    assign bus.A         = r_ops[0];
    assign bus.B         = r_ops[1];
    assign bus.C         = r_ops[2];
    assign bus.D         = r_ops[3];
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based model.
module tb_operand_loader;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    operand_loader_if #(.WIDTH(4), .CNT_W(8)) bus ();

    operand_loader #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       ab;
        logic       ordy;
        logic       ov;
        logic       ir;
        logic [1:0] idx;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ec;
        logic [3:0] ed;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d,
                         input logic ab, input logic ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.abort     = ab;
        bus.out_ready = ordy;
    endtask

    task automatic chk_ops(input string tag, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d);
        chk({tag, ".A"}, 32'(bus.A), 32'(a));
        chk({tag, ".B"}, 32'(bus.B), 32'(b));
        chk({tag, ".C"}, 32'(bus.C), 32'(c));
        chk({tag, ".D"}, 32'(bus.D), 32'(d));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            drive(vt[i].v, vt[i].d, vt[i].ab, vt[i].ordy);
            step();
            chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vt[i].ov));
            chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(vt[i].ir));
            chk({tag, ".load_idx"}, 32'(bus.load_idx), 32'(vt[i].idx));
            chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'(vt[i].cnt));
            chk_ops(tag, vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ed);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".load_idx"}, 32'(bus.load_idx), 32'd0);
        chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
        chk_ops(tag, 4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    // Reference model: a queue of nibbles collected for the current frame
    logic [3:0] q [$];
    logic [3:0] m_ops [4];
    bit         m_hold;
    int         m_cnt;
    int         m_acc;

    task automatic model_edge(input logic v, input logic [3:0] d,
                              input logic ab, input logic ordy);
        if (ab) begin
            if (m_hold) m_hold = 1'b0;
            else q.delete();
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                m_cnt  = (m_cnt + 1) % 256;
                m_acc++;
            end
        end else if (v) begin
            m_ops[q.size()] = d;
            q.push_back(d);
            if (q.size() == 4) begin
                q.delete();
                m_hold = 1'b1;
            end
        end
    endtask

    initial begin
        //     v  d     ab or  ov ir idx  A     B     C     D     cnt
        vt[0]  = '{1, 4'h3, 0, 0, 0, 1, 2'd1, 4'h3, 4'h0, 4'h0, 4'h0, 8'd0};
        vt[1]  = '{1, 4'h5, 0, 0, 0, 1, 2'd2, 4'h3, 4'h5, 4'h0, 4'h0, 8'd0};
        vt[2]  = '{1, 4'h2, 0, 0, 0, 1, 2'd3, 4'h3, 4'h5, 4'h2, 4'h0, 8'd0};
        vt[3]  = '{1, 4'h9, 0, 0, 1, 0, 2'd0, 4'h3, 4'h5, 4'h2, 4'h9, 8'd0};
        vt[4]  = '{1, 4'h7, 0, 0, 0, 1, 2'd1, 4'h7, 4'h5, 4'h2, 4'h9, 8'd1};
        vt[5]  = '{1, 4'h1, 0, 0, 0, 1, 2'd2, 4'h7, 4'h1, 4'h2, 4'h9, 8'd1};
        vt[6]  = '{1, 4'h4, 1, 0, 0, 1, 2'd0, 4'h7, 4'h1, 4'h2, 4'h9, 8'd1};
        vt[7]  = '{1, 4'h8, 0, 0, 0, 1, 2'd1, 4'h8, 4'h1, 4'h2, 4'h9, 8'd1};
        vt[8]  = '{1, 4'h6, 0, 0, 0, 1, 2'd2, 4'h8, 4'h6, 4'h2, 4'h9, 8'd1};
        vt[9]  = '{1, 4'h4, 0, 0, 0, 1, 2'd3, 4'h8, 4'h6, 4'h4, 4'h9, 8'd1};
        vt[10] = '{1, 4'h2, 0, 0, 1, 0, 2'd0, 4'h8, 4'h6, 4'h4, 4'h2, 8'd1};
        vt[11] = '{0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h8, 4'h6, 4'h4, 4'h2, 8'd1};
        vt[12] = '{1, 4'hF, 1, 1, 0, 1, 2'd0, 4'h8, 4'h6, 4'h4, 4'h2, 8'd1};
        vt[13] = '{0, 4'h0, 0, 1, 0, 1, 2'd0, 4'h8, 4'h6, 4'h4, 4'h2, 8'd1};
        vt[14] = '{1, 4'hC, 0, 0, 0, 1, 2'd1, 4'hC, 4'h6, 4'h4, 4'h2, 8'd1};
        vt[15] = '{0, 4'h0, 0, 0, 0, 1, 2'd1, 4'hC, 4'h6, 4'h4, 4'h2, 8'd1};

        // reset held two cycles with a nibble on offer
        rst = 1'b1;
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk_reset("reset");
        rst = 1'b0;

        run_rows(0, 3);

        // backpressure: ten held cycles, new data on offer is ignored
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'hA, 1'b0, 1'b0);
            step();
            chk($sformatf("bp%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            chk_ops($sformatf("bp%0d", i), 4'h3, 4'h5, 4'h2, 4'h9);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        step();
        chk("accept.out_valid", 32'(bus.out_valid), 32'd0);
        chk("accept.in_ready", 32'(bus.in_ready), 32'd1);
        chk("accept.frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk_ops("accept", 4'h3, 4'h5, 4'h2, 4'h9);

        run_rows(4, 15);

        // reset mid-frame (load_idx = 1 here)
        rst = 1'b1;
        drive(1'b1, 4'h5, 1'b0, 1'b1);
        step();
        chk_reset("midrst");
        rst = 1'b0;

        // randomized run until 257 frames accepted
        q.delete();
        for (int i = 0; i < 4; i++) m_ops[i] = 4'h0;
        m_hold = 1'b0;
        m_cnt  = 0;
        m_acc  = 0;
        begin
            int cyc;
            cyc = 0;
            while (m_acc < 257 && cyc < 20000) begin
                logic       v;
                logic [3:0] d;
                logic       ab;
                logic       ordy;
                int         prev_acc;
                v    = ($urandom_range(0, 9) < 7);
                d    = 4'($urandom);
                ab   = ($urandom_range(0, 31) == 0);
                ordy = ($urandom_range(0, 1) == 1);
                drive(v, d, ab, ordy);
                prev_acc = m_acc;
                model_edge(v, d, ab, ordy);
                step();
                cyc++;
                chk("rnd.out_valid", 32'(bus.out_valid), 32'(m_hold));
                chk("rnd.in_ready", 32'(bus.in_ready), 32'(!m_hold));
                chk("rnd.load_idx", 32'(bus.load_idx), 32'(q.size()));
                chk("rnd.frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
                chk_ops("rnd", m_ops[0], m_ops[1], m_ops[2], m_ops[3]);
                if (m_acc != prev_acc && m_acc == 256)
                    chk("wrap256", 32'(bus.frame_cnt), 32'd0);
                if (m_acc != prev_acc && m_acc == 257)
                    chk("wrap257", 32'(bus.frame_cnt), 32'd1);
            end
            if (m_acc < 257) begin
                n_chk++;
                n_fail++;
                $display("FAIL rnd_budget: got %0d frames expected 257",
                         m_acc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the team's 4-bit operator-evaluation stage. It accepts operands one nibble at a time over a valid/ready stream in fixed order A, B, C, D, then presents all four in parallel with a valid/ready handshake. Operands are held stable until the downstream stage accepts them. The outputs A–D connect directly to the same-named inputs of the combinational operator block.

## Interface
- WIDTH, 4, operand width in bits (in_data and A–D)
- CNT_W, 8, width of the frame counter
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  operand nibble being offered
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a nibble; combinational, equals (state == LOAD)
- abort  input  1  synchronous discard of the current partial or held frame
- A, B, C, D  output  WIDTH each  registered operands
- out_valid  output  1  A–D form a complete frame
- out_ready  input  1  downstream accepts the frame
- load_idx  output  2  index of the next operand to load (0 = A … 3 = D)
- frame_cnt  output  CNT_W  count of frames accepted downstream; wraps

## Operation
- **Reset values:** state = LOAD, load_idx = 0, A = B = C = D = 0, out_valid = 0, frame_cnt = 0.
  - in_ready reads 1 while rst is high, but no transfer is taken during reset.
- **Priority:** rst > abort > handshakes.
- **State LOAD**
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - On a transfer, in_data is written to operand[load_idx] and load_idx increments.
  - A transfer at load_idx = 3 writes D, wraps load_idx to 0, and moves to HOLD. out_valid goes high the next cycle.
  - in_valid low means no change (gaps are allowed at any point).
- **State HOLD**
  - out_valid = 1 and in_ready = 0. A–D are frozen and in_data is ignored.
  - out_valid && out_ready at an edge moves to LOAD, clears out_valid, and increments frame_cnt.
  - Holds indefinitely while out_ready = 0.
- **abort in LOAD:** load_idx resets to 0. Partially loaded operand registers keep their values; they are overwritten by the next frame. A transfer offered in the same cycle is dropped.
- **abort in HOLD:** returns to LOAD and clears out_valid. frame_cnt is not incremented, even if out_ready = 1 in the same cycle.
- **frame_cnt:** modulo 2^CNT_W; 255 wraps to 0 with the default CNT_W.
- **Operand register writes:** A–D change only on LOAD transfers; never in HOLD.

## Timing
- in_ready is combinational from state; every other output is registered.
- The 4th accepted nibble at edge N puts state = HOLD and out_valid = 1 after edge N.
- If out_ready is already high, the frame is accepted at edge N+1 and in_ready = 1 after edge N+1.
- There is no LOAD/HOLD overlap. Minimum frame period is 5 cycles: 4 loads plus 1 hold.
- An abort at edge M takes effect on state, load_idx and out_valid after edge M.
- Reset asserted mid-frame or mid-hold returns all outputs to reset values after that edge.

## Test plan
- **Reset:** hold rst for 2 cycles with in_valid = 1, in_data = 4'hF. Require out_valid = 0, A–D = 0, load_idx = 0, frame_cnt = 0, and no operand written.
- **Back-to-back load:** in_valid held high with 3, 5, 2, 9 on consecutive edges and out_ready = 0. Require, the cycle after the 4th edge: out_valid = 1, in_ready = 0, A = 3, B = 5, C = 2, D = 9.
- **Backpressure:** from that state, hold out_ready = 0 for 10 cycles while driving in_valid = 1, in_data = 4'hA. Require A–D and out_valid unchanged throughout. Then raise out_ready = 1 for one cycle; require out_valid = 0, in_ready = 1, frame_cnt = 1.
- **Abort mid-load:** load 7, 1, then assert abort with in_valid = 1, in_data = 4'h4. Require load_idx = 0 and that the nibble is not written. Then load 8, 6, 4, 2; require A = 8, B = 6, C = 4, D = 2.
- **Abort in HOLD:** assert abort and out_ready = 1 in the same cycle. Require out_valid = 0, state = LOAD, frame_cnt unchanged.
- **Wrap:** complete 256 frames with random gaps on in_valid and out_ready. Require frame_cnt = 0 after the 256th acceptance and 1 after the 257th.
